// File: rtl/uno_seq_pkg.sv
// Shared types and constants for the uno PE command sequencer.
package uno_seq_pkg;

  // Operand width default; must track MAC_BW in param_def.
  localparam int unsigned MacBwDefault = 12;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_DIV = 2'b01,
    OP_EXP = 2'b10,
    OP_LOG = 2'b11
  } op_e;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StMacRun  = 3'd1;
  localparam state_t StFnFirst = 3'd2;
  localparam state_t StFnLast  = 3'd3;
  localparam state_t StCapture = 3'd4;
  localparam state_t StResp    = 3'd5;

  // Function-unit coefficients, Q4.8
  localparam logic [11:0] COEFF_DIV = 12'h155;
  localparam logic [11:0] COEFF_EXP = 12'h100;
  localparam logic [11:0] COEFF_LOG = 12'h155;

  function automatic logic [11:0] coeff_of(input op_e op);
    logic [11:0] c;
    c = 12'h000;
    unique case (op)
      OP_DIV:  c = COEFF_DIV;
      OP_EXP:  c = COEFF_EXP;
      OP_LOG:  c = COEFF_LOG;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uno_seq.sv
// Command sequencer for one uno PE: turns MAC/div/exp/log commands into per-cycle PE
// controls and returns the settled PE result on a valid/ready port.
module uno_seq
  import uno_seq_pkg::*;
#(
  parameter int unsigned MAC_BW = MacBwDefault,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [MAC_BW-1:0]   cmd_x,
  input  logic [MAC_BW-1:0]   cmd_y,
  input  logic [2*MAC_BW-1:0] cmd_z,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                opd_valid,
  output logic                opd_ready,
  input  logic [MAC_BW-1:0]   opd_x,
  input  logic [MAC_BW-1:0]   opd_y,
  output logic [1:0]          pe_op,
  output logic [MAC_BW-1:0]   pe_x,
  output logic [MAC_BW-1:0]   pe_y,
  output logic [2*MAC_BW-1:0] pe_z,
  output logic [MAC_BW-1:0]   pe_coeff,
  output logic                pe_first_cycle,
  output logic                pe_last_cycle,
  output logic                pe_acc_en,
  input  logic [2*MAC_BW-1:0] pe_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*MAC_BW-1:0] res_data
);

  state_t              state_q, state_d;
  op_e                 op_q, op_d;
  logic [MAC_BW-1:0]   x_q, x_d;
  logic [MAC_BW-1:0]   y_q, y_d;
  logic [2*MAC_BW-1:0] z_q, z_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [2*MAC_BW-1:0] res_q, res_d;

  logic cmd_hs;
  logic beat;
  logic first_beat;
  logic last_beat;

  assign cmd_hs     = (state_q == StIdle) && cmd_valid;
  assign beat       = (state_q == StMacRun) && opd_valid;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == len_q);

  // Next-state, command latch, beat counter and result capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          op_d    = op_e'(cmd_op);
          x_d     = cmd_x;
          y_d     = cmd_y;
          z_d     = cmd_z;
          len_d   = cmd_len;
          cnt_d   = '0;
          state_d = (op_e'(cmd_op) == OP_MAC) ? StMacRun : StFnFirst;
        end
      end
      StMacRun: begin
        if (beat) begin
          if (last_beat) begin
            // Leaving on the last beat keeps the counter from ever wrapping.
            cnt_d   = '0;
            state_d = StCapture;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      StFnFirst: state_d = StFnLast;
      StFnLast:  state_d = StCapture;
      StCapture: begin
        // PE result register has settled by now.
        res_d   = pe_result;
        state_d = StResp;
      end
      StResp: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OP_MAC;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Per-cycle PE controls and handshake outputs decoded from state
  always_comb begin
    cmd_ready      = 1'b0;
    opd_ready      = 1'b0;
    res_valid      = 1'b0;
    pe_op          = 2'b00;
    pe_x           = '0;
    pe_y           = '0;
    pe_z           = '0;
    pe_coeff       = '0;
    pe_first_cycle = 1'b0;
    pe_last_cycle  = 1'b0;
    pe_acc_en      = 1'b0;
    case (state_q)
      StIdle: cmd_ready = 1'b1;
      StMacRun: begin
        opd_ready = 1'b1;
        pe_op     = OP_MAC;
        // Once beat 0 is in, stalls feed 0*0 with accumulate on to hold the sum.
        pe_acc_en = !first_beat;
        if (opd_valid) begin
          pe_x           = opd_x;
          pe_y           = opd_y;
          pe_z           = first_beat ? z_q : '0;
          pe_first_cycle = first_beat;
          pe_last_cycle  = last_beat;
        end
      end
      StFnFirst: begin
        pe_op          = op_q;
        pe_x           = x_q;
        pe_y           = y_q;
        pe_coeff       = MAC_BW'(coeff_of(op_q));
        pe_first_cycle = 1'b1;
      end
      StFnLast: begin
        pe_op         = op_q;
        pe_x          = x_q;
        pe_y          = y_q;
        pe_last_cycle = 1'b1;
      end
      StResp:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data = res_q;

endmodule
